tour_swap_driver: RTL and testbench
===================================

Name: tour_swap_driver

Overview:
- Initiator for the adjacent-swap checker: walks a tour stored in RAM, presents each 4-vertex window (i, i+1, i+2, i+3 mod N) to the checker, and waits for its verdict.
- When the checker reports an improvement, it writes vertices i+1 and i+2 back to RAM in swapped order.
- It accumulates total gain and swap count, and repeats passes until a pass makes no swap or MAX_PASSES is reached.
- It sits between the tour RAM and the checker in the 2-opt/local-search datapath.

Parameters:
- N, 16, tour length in vertices; legal range 4..2^AW.
- AW, 4, tour RAM address width.
- MAX_PASSES, 8, maximum full passes per start; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin run; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the run ends
- swap_count  out  16  swaps applied this run; saturates at 16'hFFFF
- gain  out  32  sum of chk_difference over applied swaps; wraps mod 2^32
- rd_en  out  1  tour RAM read enable
- rd_addr  out  AW  tour RAM read address
- rd_data  in  16  {x[15:8], y[7:0]}; valid the cycle after rd_en
- wr_en  out  1  tour RAM write enable
- wr_addr  out  AW  tour RAM write address
- wr_data  out  16  {x, y} written
- chk_rst  out  1  checker synchronous reset
- chk_x1, chk_y1, chk_x2, chk_y2, chk_x3, chk_y3, chk_x4, chk_y4  out  8 each  window coordinates
- chk_res  in  1  checker verdict; 1 means swap is better
- chk_complete  in  1  checker finished
- chk_difference  in  32  checker improvement value

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0, swap_count=0, gain=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, chk_rst=1, all chk_x*/chk_y* = 0. Reset mid-run aborts immediately with no further RAM writes.
- chk_rst is 1 in every state except WAIT.
- IDLE: when start=1, clear swap_count, gain, window index i=0, pass counter, and pass_swapped flag; go to READ. start is ignored in every other state.
- READ (5 cycles, k=0..4):
  - For k<4: rd_en=1, rd_addr=(i+k) mod N.
  - For k=1..4: capture rd_data into window register k-1.
  - After k=4, go to CHKRST.
  - chk_* outputs drive the window registers and stay stable from CHKRST through WAIT.
- CHKRST (1 cycle): chk_rst=1, then go to WAIT.
- WAIT: chk_rst=0; hold until chk_complete=1.
  - chk_complete=1 and chk_res=1: gain += chk_difference, swap_count += 1 (saturating), set pass_swapped, go to WR1.
  - chk_complete=1 and chk_res=0: go to NEXT.
  - There is no timeout; the driver waits indefinitely.
- WR1 (1 cycle): wr_en=1, wr_addr=(i+1) mod N, wr_data=window v3.
- WR2 (1 cycle): wr_en=1, wr_addr=(i+2) mod N, wr_data=window v2; then go to NEXT.
- NEXT (1 cycle):
  - If i<N-1: i+=1, go to READ. The next window reads the already-updated RAM.
  - If i=N-1 and pass_swapped=1 and passes done < MAX_PASSES: i=0, clear pass_swapped, go to READ.
  - Otherwise go to DONE.
- Index arithmetic: AW+1 bits, then reduce mod N. Windows wrap, e.g. with N=16 the window at i=14 uses addresses 14,15,0,1.
- DONE (1 cycle): done=1, busy=0 on the following cycle; return to IDLE. swap_count and gain hold until the next accepted start.
- Never assert rd_en and wr_en in the same cycle.

Test Plan:
1. Bench checker model always returns res=0. Start with N=4 → 4 windows of 5 read cycles each, no wr_en, done after 1 pass; swap_count=0, gain=0.
2. N=4, RAM = {(0,0),(20,0),(10,0),(30,0)}, model returns res=1, diff=20 for window i=0 only, res=0 otherwise. Required: RAM[1]=(10,0), RAM[2]=(20,0); swap_count=1, gain=20; a second pass runs, then done.
3. Window at i=N-2 with N=16, model res=1 → reads 14,15,0,1; writes addr 15 then addr 0.
4. Model always res=1, diff=1, MAX_PASSES=2, N=4 → exactly 8 swaps, gain=8, done after pass 2.
5. Assert rst during WAIT of window 3 → chk_rst=1, wr_en=0, busy=0 immediately; RAM unchanged afterwards; a new start runs from i=0.
6. Pulse start while busy → ignored; counters unaffected; exactly one done pulse.

Source files
------------

// File: rtl/tour_swap_driver.sv
// Local-search initiator: walks the tour RAM one 4-vertex window at a time and asks the
// adjacent-swap checker for a verdict. It writes back swapped vertices and repeats passes until the tour settles.
module tour_swap_driver #(
  parameter int N          = 16,
  parameter int AW         = 4,
  parameter int MAX_PASSES = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [15:0]   swap_count,
  output logic [31:0]   gain,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [15:0]   rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic          chk_rst,
  output logic [7:0]    chk_x1,
  output logic [7:0]    chk_y1,
  output logic [7:0]    chk_x2,
  output logic [7:0]    chk_y2,
  output logic [7:0]    chk_x3,
  output logic [7:0]    chk_y3,
  output logic [7:0]    chk_x4,
  output logic [7:0]    chk_y4,
  input  logic          chk_res,
  input  logic          chk_complete,
  input  logic [31:0]   chk_difference
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CHKRST, S_WAIT, S_WR1, S_WR2, S_NEXT, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    k;
  logic [AW-1:0] idx;
  logic [7:0]    pass_cnt;
  logic          pass_swapped;
  logic [15:0]   win [4];
  logic [8:0]    next_pass;
  logic          more_passes;
  logic          last_idx;

  // Window offsets stay below 2N, so a single conditional subtract reduces mod N.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base, input logic [2:0] off);
    logic [AW:0] sum;
    sum = {1'b0, base} + (AW+1)'(off);
    if (sum >= (AW+1)'(N)) sum = sum - (AW+1)'(N);
    return sum[AW-1:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign next_pass   = {1'b0, pass_cnt} + 9'd1;
  assign more_passes = next_pass < 9'(MAX_PASSES);
  assign last_idx    = (idx == AW'(N - 1));

  assign chk_x1 = win[0][15:8];
  assign chk_y1 = win[0][7:0];
  assign chk_x2 = win[1][15:8];
  assign chk_y2 = win[1][7:0];
  assign chk_x3 = win[2][15:8];
  assign chk_y3 = win[2][7:0];
  assign chk_x4 = win[3][15:8];
  assign chk_y4 = win[3][7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    chk_rst   = (state != S_WAIT);
    rd_en     = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_READ;
      S_READ: begin
        if (k < 3'd4) begin
          rd_en   = 1'b1;
          rd_addr = wrap_add(idx, k);
        end else begin
          state_nxt = S_CHKRST;
        end
      end
      S_CHKRST: state_nxt = S_WAIT;
      S_WAIT:   if (chk_complete) state_nxt = chk_res ? S_WR1 : S_NEXT;
      S_WR1: begin
        wr_en     = 1'b1;
        wr_addr   = wrap_add(idx, 3'd1);
        wr_data   = win[2];
        state_nxt = S_WR2;
      end
      S_WR2: begin
        wr_en     = 1'b1;
        wr_addr   = wrap_add(idx, 3'd2);
        wr_data   = win[1];
        state_nxt = S_NEXT;
      end
      S_NEXT:   state_nxt = (!last_idx || (pass_swapped && more_passes)) ? S_READ : S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Read data lags rd_en by one cycle, so step k captures the word requested at step k-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k            <= '0;
      idx          <= '0;
      pass_cnt     <= '0;
      pass_swapped <= 1'b0;
      swap_count   <= '0;
      gain         <= '0;
      for (int j = 0; j < 4; j++) win[j] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            swap_count   <= '0;
            gain         <= '0;
            idx          <= '0;
            pass_cnt     <= '0;
            pass_swapped <= 1'b0;
            k            <= '0;
          end
        end
        S_READ: begin
          if (k != 3'd0) win[2'(k - 3'd1)] <= rd_data;
          k <= (k == 3'd4) ? 3'd0 : k + 3'd1;
        end
        S_WAIT: begin
          if (chk_complete && chk_res) begin
            gain         <= gain + chk_difference;
            swap_count   <= sat_inc16(swap_count);
            pass_swapped <= 1'b1;
          end
        end
        S_NEXT: begin
          k <= '0;
          if (!last_idx) begin
            idx <= idx + AW'(1);
          end else if (pass_swapped && more_passes) begin
            idx          <= '0;
            pass_swapped <= 1'b0;
            pass_cnt     <= pass_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tour_swap_driver.sv
// Scoreboard bench for tour_swap_driver: a 4-vertex instance and a 16-vertex instance share
// one RAM model and one checker model, selected by sel.
module tb_tour_swap_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, sel;
  logic        a_start, b_start;
  logic [15:0] rd_data;
  logic        chk_res, chk_complete;
  logic [31:0] chk_difference;

  logic        a_busy, a_done, a_rd_en, a_wr_en, a_chk_rst;
  logic [15:0] a_swap_count, a_wr_data;
  logic [31:0] a_gain;
  logic [1:0]  a_rd_addr, a_wr_addr;
  logic [7:0]  a_cx [4];
  logic [7:0]  a_cy [4];

  logic        b_busy, b_done, b_rd_en, b_wr_en, b_chk_rst;
  logic [15:0] b_swap_count, b_wr_data;
  logic [31:0] b_gain;
  logic [3:0]  b_rd_addr, b_wr_addr;
  logic [7:0]  b_cx [4];
  logic [7:0]  b_cy [4];

  assign a_start = start & ~sel;
  assign b_start = start & sel;

  tour_swap_driver #(.N(4), .AW(2), .MAX_PASSES(2)) u_small (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .swap_count(a_swap_count), .gain(a_gain),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(rd_data),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .chk_rst(a_chk_rst),
    .chk_x1(a_cx[0]), .chk_y1(a_cy[0]), .chk_x2(a_cx[1]), .chk_y2(a_cy[1]),
    .chk_x3(a_cx[2]), .chk_y3(a_cy[2]), .chk_x4(a_cx[3]), .chk_y4(a_cy[3]),
    .chk_res(chk_res), .chk_complete(chk_complete), .chk_difference(chk_difference)
  );

  tour_swap_driver #(.N(16), .AW(4), .MAX_PASSES(8)) u_big (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .swap_count(b_swap_count), .gain(b_gain),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(rd_data),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .chk_rst(b_chk_rst),
    .chk_x1(b_cx[0]), .chk_y1(b_cy[0]), .chk_x2(b_cx[1]), .chk_y2(b_cy[1]),
    .chk_x3(b_cx[2]), .chk_y3(b_cy[2]), .chk_x4(b_cx[3]), .chk_y4(b_cy[3]),
    .chk_res(chk_res), .chk_complete(chk_complete), .chk_difference(chk_difference)
  );

  logic        act_busy, act_done, act_rd_en, act_wr_en, act_chk_rst;
  logic [3:0]  act_rd_addr, act_wr_addr;
  logic [15:0] act_wr_data, act_swap_count;
  logic [31:0] act_gain;
  logic [63:0] act_win;

  always_comb begin
    act_busy       = sel ? b_busy : a_busy;
    act_done       = sel ? b_done : a_done;
    act_rd_en      = sel ? b_rd_en : a_rd_en;
    act_wr_en      = sel ? b_wr_en : a_wr_en;
    act_chk_rst    = sel ? b_chk_rst : a_chk_rst;
    act_rd_addr    = sel ? b_rd_addr : {2'b00, a_rd_addr};
    act_wr_addr    = sel ? b_wr_addr : {2'b00, a_wr_addr};
    act_wr_data    = sel ? b_wr_data : a_wr_data;
    act_swap_count = sel ? b_swap_count : a_swap_count;
    act_gain       = sel ? b_gain : a_gain;
    act_win        = sel ? {b_cx[0], b_cy[0], b_cx[1], b_cy[1], b_cx[2], b_cy[2], b_cx[3], b_cy[3]}
                         : {a_cx[0], a_cy[0], a_cx[1], a_cy[1], a_cx[2], a_cy[2], a_cx[3], a_cy[3]};
  end

  logic [15:0] ram     [16];
  logic [15:0] ref_ram [16];
  int          exp_rd   [$];
  logic [63:0] exp_win  [$];
  logic [19:0] exp_wr   [$];
  logic [47:0] exp_done [$];
  int          wr_log   [$];
  int n_cmp, n_err, mode, hang_at, wait_entries, done_seen, rd_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endtask

  function automatic int mdist(input logic [15:0] a, input logic [15:0] b);
    int dx, dy;
    dx = int'(a[15:8]) - int'(b[15:8]);
    dy = int'(a[7:0]) - int'(b[7:0]);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return dx + dy;
  endfunction

  // Checker behaviour: 0 never swap, 1 Manhattan 2-opt gain, 2 always swap by 1, 3 marker x1=EE.
  function automatic void decide(input int md, input logic [63:0] w, output logic r, output logic [31:0] d);
    logic [15:0] v1, v2, v3, v4;
    int o, nw;
    v1 = w[63:48]; v2 = w[47:32]; v3 = w[31:16]; v4 = w[15:0];
    r = 1'b0;
    d = 32'd0;
    case (md)
      1: begin
        o  = mdist(v1, v2) + mdist(v3, v4);
        nw = mdist(v1, v3) + mdist(v2, v4);
        if (o > nw) begin r = 1'b1; d = 32'(o - nw); end
      end
      2: begin r = 1'b1; d = 32'd1; end
      3: if (v1[15:8] == 8'hEE && v2[15:8] > v3[15:8]) begin
        r = 1'b1;
        d = 32'(int'(v2[15:8]) - int'(v3[15:8]));
      end
      default: ;
    endcase
  endfunction

  // Reference: whole passes over an array copy of the tour; limit>=0 stops at that window's verdict.
  task automatic ref_run(input int n, input int maxp, input int limit);
    int passes, w;
    bit swapped;
    logic [15:0] sc;
    logic [31:0] g, d;
    logic [63:0] win;
    logic r;
    int a [4];
    passes = 0; w = 0; sc = 0; g = 0;
    do begin
      swapped = 0;
      for (int i = 0; i < n; i++) begin
        for (int j = 0; j < 4; j++) begin
          a[j] = (i + j) % n;
          exp_rd.push_back(a[j]);
        end
        win = {ref_ram[a[0]], ref_ram[a[1]], ref_ram[a[2]], ref_ram[a[3]]};
        exp_win.push_back(win);
        if (w == limit) return;
        w++;
        decide(mode, win, r, d);
        if (r) begin
          ref_ram[a[1]] = win[31:16];
          ref_ram[a[2]] = win[47:32];
          exp_wr.push_back({4'(a[1]), win[31:16]});
          exp_wr.push_back({4'(a[2]), win[47:32]});
          swapped = 1;
          g = g + d;
          if (sc != 16'hFFFF) sc = sc + 16'd1;
        end
      end
      passes++;
    end while (swapped && passes < maxp);
    exp_done.push_back({sc, g});
  endtask

  // Tour RAM: one-cycle read latency, write lands at the end of the wr_en cycle.
  initial begin
    logic prd, pwr;
    logic [3:0] pa, wa;
    logic [15:0] wd;
    rd_data = 16'h0;
    forever begin
      @(negedge clk);
      prd = act_rd_en; pa = act_rd_addr;
      pwr = act_wr_en; wa = act_wr_addr; wd = act_wr_data;
      @(posedge clk); #1;
      if (prd) rd_data = ram[pa];
      if (pwr) ram[wa] = wd;
    end
  end

  // Checker model: compares the presented window, then answers after a random delay.
  initial begin
    logic r_;
    logic [31:0] d_;
    logic [63:0] w_;
    int dl;
    chk_complete = 1'b0; chk_res = 1'b0; chk_difference = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (!act_chk_rst && !rst) begin
        wait_entries++;
        w_ = act_win;
        if (exp_win.size() == 0) unexpected("window_unexpected", w_);
        else check("window", w_, exp_win.pop_front());
        if (hang_at == wait_entries) begin
          for (int t = 0; t < 5000 && !act_chk_rst; t++) begin @(posedge clk); #1; end
        end else begin
          decide(mode, w_, r_, d_);
          dl = $urandom_range(0, 3);
          for (int t = 0; t < dl; t++) begin @(posedge clk); #1; end
          chk_complete = 1'b1; chk_res = r_; chk_difference = d_;
          @(posedge clk); #1;
          chk_complete = 1'b0;
          chk_res = 1'($urandom_range(0, 1));
          chk_difference = $urandom;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (act_rd_en || act_wr_en) check("rd_wr_exclusive", 64'(act_rd_en & act_wr_en), 64'd0);
    if (act_rd_en) begin
      rd_seen++;
      if (exp_rd.size() == 0) unexpected("rd_unexpected", 64'(act_rd_addr));
      else check("rd_addr", 64'(act_rd_addr), 64'(exp_rd.pop_front()));
    end
    if (act_wr_en) begin
      wr_log.push_back(int'(act_wr_addr));
      if (exp_wr.size() == 0) unexpected("wr_unexpected", {act_wr_addr, act_wr_data});
      else check("wr_addr_data", {act_wr_addr, act_wr_data}, exp_wr.pop_front());
    end
    if (act_done) begin
      done_seen++;
      if (exp_done.size() == 0) unexpected("done_unexpected", {act_swap_count, act_gain});
      else check("done_swaps_gain", {act_swap_count, act_gain}, exp_done.pop_front());
    end
  end

  task automatic prep(input logic s, input int md);
    sel = s;
    mode = md;
    exp_rd.delete(); exp_win.delete(); exp_wr.delete(); exp_done.delete(); wr_log.delete();
    wait_entries = 0;
    rd_seen = 0;
    for (int i = 0; i < 16; i++) ref_ram[i] = ram[i];
  endtask

  task automatic run(input logic s, input int md, input bit extra);
    int n, maxp, base, cyc, bad;
    prep(s, md);
    n = s ? 16 : 4;
    maxp = s ? 8 : 2;
    ref_run(n, maxp, -1);
    base = done_seen;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(act_busy), 64'd1);
    cyc = 0;
    while (done_seen == base && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      start = extra && (cyc == 7 || cyc == 40);
    end
    start = 1'b0;
    if (done_seen == base) unexpected("done_timeout", 64'(cyc));
    repeat (extra ? 30 : 3) @(posedge clk);
    #1;
    if (extra) check("single_done", 64'(done_seen - base), 64'd1);
    check("idle_after_done", {act_busy, act_done}, 64'd0);
    bad = 0;
    for (int i = 0; i < n; i++) if (ram[i] !== ref_ram[i]) bad++;
    check("ram_final", 64'(bad), 64'd0);
    check("queues_drained", 64'(exp_rd.size() + exp_wr.size() + exp_done.size() + exp_win.size()), 64'd0);
  endtask

  task automatic rand_ram();
    for (int i = 0; i < 16; i++) ram[i] = 16'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bad;
    rst = 1'b1; start = 1'b0; sel = 1'b0; mode = 0; hang_at = -1;
    n_cmp = 0; n_err = 0; wait_entries = 0; done_seen = 0; rd_seen = 0;
    for (int i = 0; i < 16; i++) ram[i] = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("rst_ctrl", {act_busy, act_done, act_rd_en, act_wr_en, act_chk_rst, act_rd_addr, act_wr_addr, act_wr_data},
            {5'b00001, 4'd0, 4'd0, 16'd0});
      check("rst_counts", {act_swap_count, act_gain}, 64'd0);
      check("rst_window", act_win, 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // No-swap run on the 4-vertex tour.
    rand_ram();
    run(1'b0, 0, 1'b0);
    check("t1_reads", 64'(rd_seen), 64'd16);
    check("t1_writes", 64'(wr_log.size()), 64'd0);
    check("t1_counts", {act_swap_count, act_gain}, 64'd0);

    // Single improving swap, then a clean second pass.
    ram[0] = 16'h0000; ram[1] = 16'h1400; ram[2] = 16'h0A00; ram[3] = 16'h1E00;
    run(1'b0, 1, 1'b0);
    check("t2_ram1", 64'(ram[1]), 64'h0A00);
    check("t2_ram2", 64'(ram[2]), 64'h1400);
    check("t2_counts", {act_swap_count, act_gain}, {16'd1, 32'd20});
    check("t2_reads", 64'(rd_seen), 64'd32);

    // Always-swap checker is bounded by MAX_PASSES=2.
    rand_ram();
    run(1'b0, 2, 1'b0);
    check("t4_counts", {act_swap_count, act_gain}, {16'd8, 32'd8});

    // Wrapping window at i=14 on the 16-vertex tour.
    rand_ram();
    for (int i = 0; i < 16; i++) if (ram[i][15:8] == 8'hEE) ram[i][15:8] = 8'h00;
    ram[14][15:8] = 8'hEE; ram[15][15:8] = 8'h50; ram[0][15:8] = 8'h20;
    run(1'b1, 3, 1'b0);
    check("t3_wr_count", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() == 2) begin
      check("t3_wr_first", 64'(wr_log[0]), 64'd15);
      check("t3_wr_second", 64'(wr_log[1]), 64'd0);
    end

    // Reset while waiting on the verdict for window 3.
    rand_ram();
    prep(1'b1, 2);
    hang_at = 4;
    ref_run(16, 8, 3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (wait_entries < 4 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    check("t5_reached_wait", 64'(wait_entries), 64'd4);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_abort", {act_chk_rst, act_wr_en, act_busy}, 64'b100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hang_at = -1;
    repeat (20) @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 16; i++) if (ram[i] !== ref_ram[i]) bad++;
    check("t5_ram", 64'(bad), 64'd0);
    check("t5_queues", 64'(exp_rd.size() + exp_wr.size() + exp_done.size() + exp_win.size()), 64'd0);
    run(1'b1, 1, 1'b0);

    // start pulses while busy must not restart the run.
    rand_ram();
    run(1'b1, 1, 1'b1);

    for (int it = 0; it < 4; it++) begin
      rand_ram();
      run(1'(it % 2), 1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
